// File: rtl/param_seq_divider.sv
// rtl/param_seq_divider.sv - iterative radix-2 restoring divider, one quotient bit per clock
// Signed two's-complement mode is enabled by defining DIV_SIGNED_EN.
module param_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-2:0] rem_q, rem_d;   // partial remainder never needs its MSB before the last step
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dz_q, dz_d;

  logic             accept, last_step, trial_neg;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, q_step, q_res, r_res, dvd_mag, dvs_mag;

  assign accept    = start_sig && (state_q != CALC);
  assign last_step = (cnt_q == CW'(1));
  assign trial     = {1'b0, rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign trial_neg = trial[WIDTH];
  assign rem_step  = trial_neg ? {rem_q, dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign q_step    = {dvd_q[WIDTH-2:0], ~trial_neg};

`ifdef DIV_SIGNED_EN
  logic qneg_q, rneg_q;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_res   = qneg_q ? -q_step   : q_step;
  assign r_res   = rneg_q ? -rem_step : rem_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_res   = q_step;
  assign r_res   = rem_step;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_sig) state_d = (divisor == '0) ? DONE : CALC;
        else           state_d = IDLE;
      end
      CALC:    if (last_step) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dz_d  = dz_q;
    if (accept) begin
      dvd_d = dvd_mag;
      dvs_d = dvs_mag;
      rem_d = '0;
      if (divisor == '0) begin
        cnt_d = '0;
        quo_d = '1;
        rmd_d = dividend;
        dz_d  = 1'b1;
      end else begin
        cnt_d = CW'(WIDTH);
        quo_d = '0;
        rmd_d = '0;
        dz_d  = 1'b0;
      end
    end else if (state_q == CALC) begin
      dvd_d = q_step;
      rem_d = rem_step[WIDTH-2:0];
      cnt_d = cnt_q - CW'(1);
      if (last_step) begin
        quo_d = q_res;
        rmd_d = r_res;
      end
    end
  end

  always_comb begin
    busy      = (state_q == CALC);
    done_sig  = (state_q == DONE);
    quotient  = quo_q;
    remainder = rmd_q;
    div_zero  = dz_q;
  end
endmodule

// File: tb/tb_param_seq_divider.sv
// tb/tb_param_seq_divider.sv - randomized self-checking bench for param_seq_divider (WIDTH=8)
// Reference results come from plain integer division; latency from the cycle rules.
module tb_param_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start_sig, busy, done_sig, div_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  int           n_vec = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  param_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_sig(start_sig),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done_sig(done_sig),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb, tq, tr;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      tq = sa / sb;
      tr = sa % sb;
      q = tq[W-1:0]; r = tr[W-1:0]; dz = 1'b0;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a; divisor = b; start_sig = 1'b1;
    @(posedge clk);
    #1 start_sig = 1'b0;
  endtask

  // Samples each cycle after the accepting edge; lat is the cycle index where done_sig is seen.
  task automatic wait_done(input int poke_at, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == poke_at + 1) start_sig = 1'b0;
      if (busy) bcnt++;
      if (done_sig) break;
      if (lat == poke_at) begin
        start_sig = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end
      if (lat >= 40) begin
        n_vec++; n_bad++;
        $display("FAIL done_timeout: no done_sig after %0d cycles", lat);
        break;
      end
    end
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input int bcnt);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, ebc;
    ref_div(a, b, eq, er, ez);
    elat = (b == '0) ? 1 : W + 1;
    ebc  = (b == '0) ? 0 : W;
    n_vec++;
    if (quotient !== eq) begin n_bad++; $display("FAIL %s quotient %0d/%0d: got %h want %h", nm, a, b, quotient, eq); end
    n_vec++;
    if (remainder !== er) begin n_bad++; $display("FAIL %s remainder %0d/%0d: got %h want %h", nm, a, b, remainder, er); end
    n_vec++;
    if (div_zero !== ez) begin n_bad++; $display("FAIL %s div_zero %0d/%0d: got %b want %b", nm, a, b, div_zero, ez); end
    n_vec++;
    if (lat !== elat) begin n_bad++; $display("FAIL %s latency %0d/%0d: got %0d want %0d", nm, a, b, lat, elat); end
    n_vec++;
    if (bcnt !== ebc) begin n_bad++; $display("FAIL %s busy_cycles %0d/%0d: got %0d want %0d", nm, a, b, bcnt, ebc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_sig = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done_sig, div_zero, quotient, remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
               busy, done_sig, div_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [W-1:0] q0;
    issue(8'd243, 8'd10);
    wait_done(0, lat, bc);
    check_op("basic", 8'd243, 8'd10, lat, bc);
    q0 = quotient;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done_sig !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_return_idle: got done=%b busy=%b want 0 0", done_sig, busy);
    end
    n_vec++;
    if (quotient !== q0) begin n_bad++; $display("FAIL basic_hold: got %h want %h", quotient, q0); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    issue(8'd7, 8'd0);
    wait_done(0, lat, bc);
    check_op("div_zero", 8'd7, 8'd0, lat, bc);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(8'd5, 8'd9);
    wait_done(0, lat, bc);
    check_op("b2b_first", 8'd5, 8'd9, lat, bc);
    issue(8'd255, 8'd1);
    wait_done(0, lat, bc);
    check_op("b2b_second", 8'd255, 8'd1, lat, bc);
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    issue(8'd200, 8'd7);
    wait_done(3, lat, bc);
    check_op("ignore_start", 8'd200, 8'd7, lat, bc);
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done_sig !== 1'b0) begin
      n_bad++; $display("FAIL ignore_not_queued: got busy=%b done=%b want 0 0", busy, done_sig);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    issue(8'd100, 8'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done_sig, div_zero, quotient, remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
               busy, done_sig, div_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done_sig) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_bad++; $display("FAIL reset_mid_abort: activity cycles got %0d want 0", seen); end
    issue(8'd100, 8'd3);
    wait_done(0, lat, bc);
    check_op("after_reset", 8'd100, 8'd3, lat, bc);
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc, gap;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 3));
        default: b = W'($urandom);
      endcase
      issue(a, b);
      wait_done(0, lat, bc);
      check_op("random", a, b, lat, bc);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    @(negedge clk);
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    logic [W-1:0] ta [3] = '{8'hF9, 8'h80, 8'h07};
    logic [W-1:0] tb [3] = '{8'h02, 8'hFF, 8'hFE};
    logic [W-1:0] tq [3] = '{8'hFD, 8'h80, 8'hFD};
    logic [W-1:0] tr [3] = '{8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i]);
      wait_done(0, lat, bc);
      n_vec++;
      if (quotient !== tq[i] || remainder !== tr[i]) begin
        n_bad++;
        $display("FAIL signed_%0d: got q=%h r=%h want q=%h r=%h", i, quotient, remainder, tq[i], tr[i]);
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
